// File: rtl/pipe_stage_buf_pkg.sv
// Shared pipeline definitions: boolean/word constants, per-stage payload
// layouts and the NOP payloads each stage buffer drives while empty.
package pipe_stage_buf_pkg;

    localparam logic True  = 1'b1;
    localparam logic False = 1'b0;

    localparam int          WORD_W   = 32;
    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    localparam int         REG_ADDR_W = 5;
    localparam logic [4:0] NOPRegAddr = 5'b00000;

    localparam int         ALU_OP_W = 8;
    localparam logic [7:0] EX_NOP   = 8'h00;

    // IF/ID payload, packed MSB first: {pc, inst}
    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] inst;
    } if_id_t;

    // ID/EX payload, packed MSB first: {alu_op, reg1, reg2, wd, w_req}
    typedef struct packed {
        logic [ALU_OP_W-1:0]   alu_op;
        logic [WORD_W-1:0]     reg1;
        logic [WORD_W-1:0]     reg2;
        logic [REG_ADDR_W-1:0] wd;
        logic                  w_req;
    } id_ex_t;

    // EX/MEM payload, packed MSB first: {wd, w_req, wdata}
    typedef struct packed {
        logic [REG_ADDR_W-1:0] wd;
        logic                  w_req;
        logic [WORD_W-1:0]     wdata;
    } ex_mem_t;

    localparam int IF_ID_W  = $bits(if_id_t);
    localparam int ID_EX_W  = $bits(id_ex_t);
    localparam int EX_MEM_W = $bits(ex_mem_t);

    // Bubbles: an empty stage buffer must look like a NOP to the next stage
    localparam if_id_t  IF_ID_NOP  = '{pc: ZeroWord, inst: ZeroWord};
    localparam id_ex_t  ID_EX_NOP  = '{alu_op: EX_NOP, reg1: ZeroWord, reg2: ZeroWord,
                                       wd: NOPRegAddr, w_req: False};
    localparam ex_mem_t EX_MEM_NOP = '{wd: NOPRegAddr, w_req: False, wdata: ZeroWord};

    function automatic logic [ID_EX_W-1:0] pack_id_ex(input id_ex_t f);
        return f;
    endfunction

    function automatic id_ex_t unpack_id_ex(input logic [ID_EX_W-1:0] d);
        return id_ex_t'(d);
    endfunction

    function automatic logic [EX_MEM_W-1:0] pack_ex_mem(input ex_mem_t f);
        return f;
    endfunction

    function automatic ex_mem_t unpack_ex_mem(input logic [EX_MEM_W-1:0] d);
        return ex_mem_t'(d);
    endfunction

endpackage

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register: DEPTH-entry circular buffer with
// valid/ready handshakes, a global rdy freeze and a flush that bubbles
// every buffered and incoming entry. Outputs depend on registers only.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 2,
    parameter logic [WIDTH-1:0] NOP_DATA = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    // Modulo-DEPTH increment; explicit wrap so non-power-of-2 depths work
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST) ? '0 : p + PTR_W'(1);
    endfunction

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] cnt_q;
    logic             push;
    logic             pop;
    logic             xfer_en;

    // in_ready comes from count alone: no out_ready -> in_ready path, so a
    // full buffer only reopens the cycle after a pop.
    assign in_ready  = (cnt_q < FULL);
    assign out_valid = (cnt_q != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : NOP_DATA;
    assign count     = cnt_q;

    assign push    = in_valid & in_ready;
    assign pop     = out_valid & out_ready;
    // Handshakes only take effect when the pipe runs and is not being killed
    assign xfer_en = rdy & ~flush;

    // Pointer/occupancy update: rst > !rdy > flush > push/pop
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (rdy) begin
            if (flush) begin
                cnt_q  <= '0;
                rd_ptr <= wr_ptr;
            end else begin
                if (push) wr_ptr <= ptr_inc(wr_ptr);
                if (pop)  rd_ptr <= ptr_inc(rd_ptr);
                case ({push, pop})
                    2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                    2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                    default: cnt_q <= cnt_q;
                endcase
            end
        end
    end

    // Payload storage; no reset needed since entries are qualified by count
    always_ff @(posedge clk) begin
        if (!rst && xfer_en && push) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule
